mips_cpu_control: RTL

Multi-cycle control sequencer for the MIPS CPU. It drives the other end of the ALU interface: it fetches and latches each instruction, decodes it, issues the 5-bit `alu_control` code and operand selects, and consumes the ALU `zero` flag to resolve branches. It also sequences instruction-fetch and load/store memory transactions with a wait-request handshake and flags halt.

---
 rtl/mips_cpu_control.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_control.sv
// mips_cpu_control
//   Multi-cycle control sequencer for the MIPS CPU. Fetches and latches each
//   instruction, decodes it, drives ALU operation/operand selects, resolves
//   branches from the ALU zero flag and sequences memory accesses with a
//   wait-request handshake.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_readdata      instruction word, captured at the end of fetch
//   mem_waitrequest   memory stall, holds the current access
//   zero              ALU zero flag (branch condition, valid in EXEC)
//   pc_zero           datapath PC equals 0 (halt request, sampled in FETCH)
//   mem_read/write    memory strobes; iord selects address (0 PC, 1 ALU)
//   ir_write, pc_write, reg_write   single-cycle enables
//   alu_src_a/b, alu_control        ALU operand selects and operation code
//   reg_dst, wb_src, pc_src         write-back / PC source selects
//   active            high until halt
module mips_cpu_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   input  logic        zero,
   input  logic        pc_zero,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [4:0]  alu_control,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wb_src,
   output logic [1:0]  pc_src,
   output logic        active
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      K_NOP, K_ALU, K_BRANCH, K_JUMP, K_JAL, K_LUI, K_LOAD, K_STORE
   } kind_t;

   typedef struct packed {
      kind_t      kind;
      logic [4:0] alu;
      logic       src_a;
      logic [1:0] src_b;
      logic [1:0] pc_src;   // jump target vs rs for K_JUMP
      logic       rtype;    // R-type write-back goes to rd
   } dec_t;

   localparam logic [4:0] ALU_AND  = 5'b00000, ALU_OR   = 5'b00001,
                          ALU_ADD  = 5'b00010, ALU_SUB  = 5'b00110,
                          ALU_SLTU = 5'b00111, ALU_SLT  = 5'b01000,
                          ALU_SLL  = 5'b01001, ALU_SRA  = 5'b01010,
                          ALU_SRL  = 5'b01011, ALU_NOR  = 5'b01100,
                          ALU_XOR  = 5'b01101, ALU_SLLV = 5'b01110,
                          ALU_SRAV = 5'b01111, ALU_SRLV = 5'b10000,
                          ALU_BNE  = 5'b11000, ALU_BGTZ = 5'b11001,
                          ALU_BLEZ = 5'b11010, ALU_BGEZ = 5'b11011,
                          ALU_BLTZ = 5'b11111;

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   dec_t        dec;

   // Only opcode, rt and funct steer the sequencer; the rest of the IR
   // belongs to the datapath.
   logic ir_unused;
   assign ir_unused = ^{ir_q[25:21], ir_q[15:6]};

   // Instruction decode from the latched IR.
   always_comb begin
      dec.kind   = K_NOP;
      dec.alu    = 5'b00000;
      dec.src_a  = 1'b1;
      dec.src_b  = 2'd0;
      dec.pc_src = 2'd0;
      dec.rtype  = 1'b0;
      case (ir_q[31:26])
         6'h00: begin
            dec.kind  = K_ALU;
            dec.rtype = 1'b1;
            case (ir_q[5:0])
               6'h21:   dec.alu = ALU_ADD;
               6'h23:   dec.alu = ALU_SUB;
               6'h24:   dec.alu = ALU_AND;
               6'h25:   dec.alu = ALU_OR;
               6'h26:   dec.alu = ALU_XOR;
               6'h27:   dec.alu = ALU_NOR;
               6'h2a:   dec.alu = ALU_SLT;
               6'h2b:   dec.alu = ALU_SLTU;
               6'h00:   dec.alu = ALU_SLL;
               6'h03:   dec.alu = ALU_SRA;
               6'h02:   dec.alu = ALU_SRL;
               6'h04:   dec.alu = ALU_SLLV;
               6'h07:   dec.alu = ALU_SRAV;
               6'h06:   dec.alu = ALU_SRLV;
               6'h08: begin
                  dec.kind   = K_JUMP;
                  dec.src_a  = 1'b0;
                  dec.pc_src = 2'd3;
               end
               default: dec.kind = K_NOP;
            endcase
         end
         6'h01: begin
            // REGIMM: rt selects the comparison, other rt values are NOPs.
            dec.kind = K_BRANCH;
            case (ir_q[20:16])
               5'd0:    dec.alu = ALU_BLTZ;
               5'd1:    dec.alu = ALU_BGEZ;
               default: dec.kind = K_NOP;
            endcase
         end
         6'h02: begin dec.kind = K_JUMP; dec.src_a = 1'b0; dec.pc_src = 2'd2; end
         6'h03: begin dec.kind = K_JAL;  dec.src_a = 1'b0; end
         6'h04: begin dec.kind = K_BRANCH; dec.alu = ALU_SUB;  end
         6'h05: begin dec.kind = K_BRANCH; dec.alu = ALU_BNE;  end
         6'h06: begin dec.kind = K_BRANCH; dec.alu = ALU_BLEZ; end
         6'h07: begin dec.kind = K_BRANCH; dec.alu = ALU_BGTZ; end
         6'h09: begin dec.kind = K_ALU; dec.alu = ALU_ADD;  dec.src_b = 2'd2; end
         6'h0a: begin dec.kind = K_ALU; dec.alu = ALU_SLT;  dec.src_b = 2'd2; end
         6'h0b: begin dec.kind = K_ALU; dec.alu = ALU_SLTU; dec.src_b = 2'd2; end
         6'h0c: begin dec.kind = K_ALU; dec.alu = ALU_AND;  dec.src_b = 2'd3; end
         6'h0d: begin dec.kind = K_ALU; dec.alu = ALU_OR;   dec.src_b = 2'd3; end
         6'h0e: begin dec.kind = K_ALU; dec.alu = ALU_XOR;  dec.src_b = 2'd3; end
         6'h0f: begin dec.kind = K_LUI; dec.src_a = 1'b0; end
         6'h23: begin dec.kind = K_LOAD;  dec.alu = ALU_ADD; dec.src_b = 2'd2; end
         6'h2b: begin dec.kind = K_STORE; dec.alu = ALU_ADD; dec.src_b = 2'd2; end
         default: dec.src_a = 1'b0;
      endcase
   end

   // NOTE: every output and next-state value gets a default before the case so
   // no path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'd0;
      alu_control = 5'b00000;
      reg_dst     = 2'd0;
      wb_src      = 2'd0;
      pc_src      = 2'd0;
      active      = (state_q != S_HALT);

      case (state_q)
         S_FETCH: begin
            if (pc_zero) begin
               state_d = S_HALT;
            end else begin
               // PC+4 operands are held for the whole fetch so they are
               // stable across a stall; the writes fire on the last cycle.
               mem_read    = 1'b1;
               alu_src_b   = 2'd1;
               alu_control = ALU_ADD;
               if (!mem_waitrequest) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  ir_d     = mem_readdata;
                  state_d  = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            case (dec.kind)
               K_NOP:        state_d = S_FETCH;
               K_LUI, K_JAL: state_d = S_WB;
               default:      state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            alu_src_a   = dec.src_a;
            alu_src_b   = dec.src_b;
            alu_control = dec.alu;
            state_d     = S_FETCH;
            case (dec.kind)
               K_ALU:            state_d = S_WB;
               K_LOAD, K_STORE:  state_d = S_MEM;
               K_BRANCH: begin
                  pc_src   = 2'd1;
                  pc_write = zero;
               end
               K_JUMP: begin
                  pc_src   = dec.pc_src;
                  pc_write = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            // Address operands stay on the ALU for the whole access.
            alu_src_a   = dec.src_a;
            alu_src_b   = dec.src_b;
            alu_control = dec.alu;
            iord        = 1'b1;
            mem_read    = (dec.kind == K_LOAD);
            mem_write   = (dec.kind == K_STORE);
            if (!mem_waitrequest)
               state_d = (dec.kind == K_LOAD) ? S_WB : S_FETCH;
         end
         S_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
            case (dec.kind)
               K_ALU: begin
                  // The ALU result feeds the register file directly, so
                  // keep its operands applied through write-back.
                  alu_src_a   = dec.src_a;
                  alu_src_b   = dec.src_b;
                  alu_control = dec.alu;
                  reg_dst     = dec.rtype ? 2'd1 : 2'd0;
               end
               K_LOAD: wb_src = 2'd1;
               K_LUI:  wb_src = 2'd3;
               K_JAL: begin
                  // Link and jump together: $31 captures the current PC+4
                  // on the same edge the PC takes the jump target.
                  reg_dst  = 2'd2;
                  wb_src   = 2'd2;
                  pc_src   = 2'd2;
                  pc_write = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;   // S_HALT: quiet until reset
      endcase

      // While reset is held the outputs are forced quiet combinationally, so
      // a strobe or write in flight is dropped in the cycle reset asserts.
      if (!rst_n) begin
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         iord        = 1'b0;
         ir_write    = 1'b0;
         pc_write    = 1'b0;
         reg_write   = 1'b0;
         alu_src_a   = 1'b0;
         alu_src_b   = 2'd0;
         alu_control = 5'b00000;
         reg_dst     = 2'd0;
         wb_src      = 2'd0;
         pc_src      = 2'd0;
         active      = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values from before the edge; the IR is a single register,
   // not a memory array, so it is reset along with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

endmodule
